// File: rtl/alu_sequencer.sv
// Multi-cycle ALU command sequencer: reads two registers, drives the external ALU,
// writes the result back (unless rd is r0) and returns the result over a handshake.
module alu_sequencer #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_aluop,
    input  logic [3:0]       cmd_func,
    input  logic [4:0]       cmd_rs1,
    input  logic [4:0]       cmd_rs2,
    input  logic [4:0]       cmd_rd,
    output logic [4:0]       RR1,
    output logic [4:0]       RR2,
    input  logic [Width-1:0] RD1,
    input  logic [Width-1:0] RD2,
    output logic [4:0]       WR1,
    output logic [Width-1:0] WD,
    output logic             reg_wr,
    output logic [1:0]       Aluop,
    output logic [3:0]       func,
    output logic [Width-1:0] op1,
    output logic [Width-1:0] op2,
    input  logic [Width-1:0] aluOut,
    input  logic             carry,
    input  logic             zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [Width-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             busy,
    output logic [15:0]      op_count
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WB,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         aluop_q, aluop_d;
    logic [3:0]         func_q, func_d;
    logic [4:0]         rs1_q, rs1_d;
    logic [4:0]         rs2_q, rs2_d;
    logic [4:0]         rd_q, rd_d;
    logic [Width-1:0]   opa_q, opa_d;
    logic [Width-1:0]   opb_q, opb_d;
    logic [Width-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               reg_wr_q, reg_wr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [15:0]        op_count_q, op_count_d;

    always_comb begin
        state_d     = state_q;
        aluop_d     = aluop_q;
        func_d      = func_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        reg_wr_d    = 1'b0;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    aluop_d = cmd_aluop;
                    func_d  = cmd_func;
                    rs1_d   = cmd_rs1;
                    rs2_d   = cmd_rs2;
                    rd_d    = cmd_rd;
                    state_d = READ;
                end
            end
            READ: begin
                opa_d   = RD1;
                opb_d   = RD2;
                state_d = EXEC;
            end
            EXEC: begin
                result_d = aluOut;
                carry_d  = carry;
                zero_d   = zero;
                // Write enable is registered, so it is decided one state early; r0 is never written.
                reg_wr_d = (rd_q != 5'd0);
                state_d  = WB;
            end
            WB: begin
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            aluop_q     <= 2'd0;
            func_q      <= 4'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            reg_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            aluop_q     <= aluop_d;
            func_q      <= func_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            reg_wr_q    <= reg_wr_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    // Every datapath output comes straight from a latch register, so it holds outside its active state.
    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign RR1        = rs1_q;
    assign RR2        = rs2_q;
    assign op1        = opa_q;
    assign op2        = opb_q;
    assign Aluop      = aluop_q;
    assign func       = func_q;
    assign WR1        = rd_q;
    assign WD         = result_q;
    assign reg_wr     = reg_wr_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural register file and ALU stub around the DUT,
// directed scenarios followed by random commands checked against an arithmetic model.
module tb_alu_sequencer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_aluop;
    logic [3:0]   cmd_func;
    logic [4:0]   cmd_rs1;
    logic [4:0]   cmd_rs2;
    logic [4:0]   cmd_rd;
    logic [4:0]   RR1;
    logic [4:0]   RR2;
    logic [W-1:0] RD1;
    logic [W-1:0] RD2;
    logic [4:0]   WR1;
    logic [W-1:0] WD;
    logic         reg_wr;
    logic [1:0]   Aluop;
    logic [3:0]   func;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [W-1:0] aluOut;
    logic         carry;
    logic         zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;
    logic         rsp_zero;
    logic         busy;
    logic [15:0]  op_count;

    logic [W-1:0] init_rf  [32];
    logic [W-1:0] rf_w     [32];
    bit           wr_flag  [32];
    logic [W-1:0] model_rf [32];
    logic         stub_forced;
    logic [15:0]  exp_count;
    int           total;
    int           bad;

    alu_sequencer #(.Width(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_aluop  (cmd_aluop),
        .cmd_func   (cmd_func),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_rd     (cmd_rd),
        .RR1        (RR1),
        .RR2        (RR2),
        .RD1        (RD1),
        .RD2        (RD2),
        .WR1        (WR1),
        .WD         (WD),
        .reg_wr     (reg_wr),
        .Aluop      (Aluop),
        .func       (func),
        .op1        (op1),
        .op2        (op2),
        .aluOut     (aluOut),
        .carry      (carry),
        .zero       (zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rf_read(input logic [4:0] a);
        return wr_flag[a] ? rf_w[a] : init_rf[a];
    endfunction

    // Register file: preload values until a location is written by the DUT.
    assign RD1 = rf_read(RR1);
    assign RD2 = rf_read(RR2);

    always @(posedge clk) begin
        if (reg_wr) begin
            rf_w[WR1]    <= WD;
            wr_flag[WR1] <= 1'b1;
        end
    end

    // ALU stub: an adder, or a forced all-flags-set zero result.
    assign {carry, aluOut} = stub_forced ? {1'b1, {W{1'b0}}} : ({1'b0, op1} + {1'b0, op2});
    assign zero = stub_forced ? 1'b1 : (aluOut == '0);

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full command; hold = cycles rsp_ready stays low after rsp_valid rises.
    task automatic applyStimulus(input logic [1:0] aop, input logic [3:0] fn,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [4:0] d, input int hold);
        int unsigned  sum;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e_res;
        logic         e_c;
        logic         e_z;
        a = model_rf[s1];
        b = model_rf[s2];
        if (stub_forced) begin
            e_res = '0;
            e_c   = 1'b1;
            e_z   = 1'b1;
        end else begin
            sum   = int'(a) + int'(b);
            e_res = sum[W-1:0];
            e_c   = (sum >= (1 << W));
            e_z   = (e_res == '0);
        end

        checkOutput("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_aluop = aop;
        cmd_func  = fn;
        cmd_rs1   = s1;
        cmd_rs2   = s2;
        cmd_rd    = d;
        rsp_ready = 1'b0;
        for (int cyc = 1; cyc <= 4 + hold; cyc++) begin
            waitCycle();
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_aluop = 2'($urandom);
            cmd_func  = 4'($urandom);
            cmd_rs1   = 5'($urandom);
            cmd_rs2   = 5'($urandom);
            cmd_rd    = 5'($urandom);
            checkOutput("busy", busy, 1);
            checkOutput("cmd_ready_busy", cmd_ready, 0);
            checkOutput("reg_wr", reg_wr, (cyc == 3 && d != 5'd0));
            checkOutput("rsp_valid", rsp_valid, (cyc >= 4));
            if (cyc == 1) begin
                checkOutput("RR1", RR1, s1);
                checkOutput("RR2", RR2, s2);
            end
            if (cyc == 2) begin
                checkOutput("op1", op1, a);
                checkOutput("op2", op2, b);
                checkOutput("Aluop", Aluop, aop);
                checkOutput("func", func, fn);
            end
            if (cyc == 3) begin
                checkOutput("WR1", WR1, d);
                checkOutput("WD", WD, e_res);
            end
            if (cyc >= 4) begin
                checkOutput("rsp_result", rsp_result, e_res);
                checkOutput("rsp_carry", rsp_carry, e_c);
                checkOutput("rsp_zero", rsp_zero, e_z);
            end
            if (cyc == 4 + hold) begin
                rsp_ready = 1'b1;
                cmd_valid = 1'b0;
            end
        end
        exp_count = exp_count + 16'd1;
        waitCycle();
        rsp_ready = 1'b0;
        checkOutput("op_count", op_count, exp_count);
        checkOutput("rsp_valid_done", rsp_valid, 0);
        checkOutput("cmd_ready_done", cmd_ready, 1);
        checkOutput("busy_done", busy, 0);
        if (d != 5'd0) model_rf[d] = e_res;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total       = 0;
        bad         = 0;
        exp_count   = 16'd0;
        stub_forced = 1'b0;
        rst         = 1'b0;
        cmd_valid   = 1'b0;
        cmd_aluop   = 2'd0;
        cmd_func    = 4'd0;
        cmd_rs1     = 5'd0;
        cmd_rs2     = 5'd0;
        cmd_rd      = 5'd0;
        rsp_ready   = 1'b0;
        for (int i = 0; i < 32; i++) init_rf[i] = W'($urandom);
        init_rf[0] = 8'd10;
        init_rf[1] = 8'd4;
        for (int i = 0; i < 32; i++) model_rf[i] = init_rf[i];

        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_reg_wr", reg_wr, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_op_count", op_count, 0);
        checkOutput("rst_rsp_result", rsp_result, 0);
        checkOutput("rst_WR1", WR1, 0);
        checkOutput("rst_op1", op1, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("post_rst_cmd_ready", cmd_ready, 1);

        // Reset pulsed while in WB abandons the command.
        cmd_valid = 1'b1;
        cmd_rs1   = 5'd3;
        cmd_rs2   = 5'd4;
        cmd_rd    = 5'd5;
        waitCycle();
        cmd_valid = 1'b0;
        waitCycle();
        waitCycle();
        checkOutput("wb_reg_wr_pre_rst", reg_wr, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("wb_rst_reg_wr", reg_wr, 0);
        checkOutput("wb_rst_busy", busy, 0);
        checkOutput("wb_rst_cmd_ready", cmd_ready, 1);
        checkOutput("wb_rst_rsp_valid", rsp_valid, 0);
        checkOutput("wb_rst_WD", WD, 0);
        checkOutput("wb_rst_RR1", RR1, 0);
        waitCycle();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            waitCycle();
            checkOutput("abandon_rsp_valid", rsp_valid, 0);
            checkOutput("abandon_busy", busy, 0);
        end
        checkOutput("abandon_op_count", op_count, 0);
        checkOutput("abandon_no_write", wr_flag[5], 0);

        // r0=10, r1=4 -> r2=14.
        applyStimulus(2'd0, 4'd2, 5'd0, 5'd1, 5'd2, 0);
        checkOutput("r2_is_14", rf_read(5'd2), 14);
        checkOutput("op_count_one", op_count, 1);

        // Destination r0 is never written, response still completes.
        applyStimulus(2'd1, 4'd3, 5'd1, 5'd2, 5'd0, 0);
        checkOutput("r0_not_written", wr_flag[0], 0);

        // Consumer stalls for five cycles.
        applyStimulus(2'd2, 4'd7, 5'd2, 5'd2, 5'd6, 5);

        // Forced zero result with both flags set.
        stub_forced = 1'b1;
        applyStimulus(2'd3, 4'd15, 5'd7, 5'd8, 5'd9, 1);
        stub_forced = 1'b0;

        for (int n = 0; n < 24; n++) begin
            applyStimulus(2'($urandom), 4'($urandom), 5'($urandom), 5'($urandom),
                          5'($urandom), int'($urandom_range(0, 3)));
        end

        // Count wrap: preload FFFF, one more completion returns to zero.
        force dut.op_count_q = 16'hFFFF;
        waitCycle();
        release dut.op_count_q;
        waitCycle();
        checkOutput("op_count_preload", op_count, 16'hFFFF);
        exp_count = 16'hFFFF;
        applyStimulus(2'd0, 4'd0, 5'd10, 5'd11, 5'd12, 0);
        checkOutput("op_count_wrap", op_count, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter Width, default 8, data width of register-file and ALU operands/results.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_aluop  input  2  Aluop for ALU control.
REQ-007 cmd_func  input  4  func for ALU control.
REQ-008 cmd_rs1, cmd_rs2, cmd_rd  input  5 each  source and destination register addresses.
REQ-009 RR1, RR2  output  5 each  register-file read addresses.
REQ-010 RD1, RD2  input  Width each  register-file read data, combinational from RR1/RR2.
REQ-011 WR1  output  5  register-file write address.
REQ-012 WD  output  Width  register-file write data.
REQ-013 reg_wr  output  1  register-file write enable.
REQ-014 Aluop  output  2; func  output  4  drive ALU control.
REQ-015 op1, op2  output  Width each  ALU operands.
REQ-016 aluOut  input  Width; carry  input  1; zero  input  1  ALU results, combinational from op1/op2/control.
REQ-017 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-018 rsp_result  output  Width; rsp_carry, rsp_zero  output  1 each  latched ALU result and flags.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 op_count  output  16  number of completed responses.

Function
REQ-021 FSM states IDLE, READ, EXEC, WB, RESP; one cycle each except IDLE and RESP.
REQ-022 cmd_ready = 1 only in IDLE; accept when cmd_valid & cmd_ready on a rising edge; latch aluop, func, rs1, rs2, rd; go to READ.
REQ-023 READ: RR1 = latched rs1, RR2 = latched rs2; at edge capture RD1/RD2 into operand registers; go to EXEC.
REQ-024 EXEC: op1/op2 = operand registers, Aluop/func = latched values; at edge capture aluOut, carry, zero into result registers; go to WB.
REQ-025 WB: WR1 = latched rd, WD = result register, reg_wr = 1 for exactly this cycle; go to RESP.
REQ-026 Writes to rd = 0 suppressed: reg_wr stays 0 in WB when rd = 0; response still issued.
REQ-027 RESP: rsp_valid = 1, rsp_result/carry/zero stable; hold until rsp_valid & rsp_ready at an edge, then IDLE and op_count increments.
REQ-028 Latency: accept in cycle C0 -> READ C1, EXEC C2, WB C3, rsp_valid first high C4.
REQ-029 Back-to-back: next command accepted no earlier than the cycle after the RESP handshake (C5 with rsp_ready tied high).
REQ-030 reg_wr = 0 in all states except WB; RR/WR/op/Aluop/func outputs hold last values outside their active states.
REQ-031 op_count wraps 16'hFFFF -> 16'h0000.
REQ-032 cmd_valid outside IDLE ignored; cmd inputs may change freely after acceptance.

Reset
REQ-033 rst = 1 immediately forces IDLE, reg_wr = 0, rsp_valid = 0, busy = 0, cmd_ready = 1 after release, without waiting for clk.
REQ-034 Reset clears all latched command, operand, result registers, outputs and op_count to 0.
REQ-035 Reset mid-operation abandons the command: no write, no response, no count increment.

Verification
REQ-036 Regs r0=10, r1=4, ALU stub aluOut=op1+op2; command rs1=0, rs2=1, rd=2 -> reg_wr high exactly in C3 with WR1=2, WD=14; rsp_valid in C4, rsp_result=14, op_count=1.
REQ-037 rd=0 command -> reg_wr never asserts; rsp_valid still in C4; op_count increments.
REQ-038 rsp_ready held low 5 cycles -> rsp_valid and rsp_result stay constant, cmd_ready stays 0; completion on first rsp_ready cycle.
REQ-039 ALU stub aluOut=0, zero=1, carry=1 -> rsp_zero=1, rsp_carry=1, rsp_result=0.
REQ-040 rst pulsed during WB -> reg_wr drops immediately, state IDLE, rsp_valid never asserts, op_count unchanged.
REQ-041 Preload op_count to 16'hFFFF via 65535 ops (or forced) then one more -> op_count=16'h0000.
